// File: rtl/entry_seq_pkg.sv
// Shared types and constants for the calculator entry sequencer.
// Stage offsets are added to N_OPERANDS to form the stage output.
package entry_seq_pkg;

   typedef enum logic [1:0] {
      ENTRY,
      OP_SELECT,
      OP_ARMED,
      SHOW
   } seq_state_t;

   localparam int STAGE_OP_OFS   = 0;
   localparam int STAGE_SHOW_OFS = 1;

endpackage

// File: rtl/entry_digit_counter.sv
// Saturating per-operand press counter.
// cnt and sat are both registers so they can drive outputs directly.
module entry_digit_counter
   import entry_seq_pkg::*;
#(
   parameter int MAX_DIGITS = 4,
   parameter int DIG_W      = $clog2(MAX_DIGITS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [DIG_W-1:0] cnt,
   output logic             sat
);

   localparam logic [DIG_W-1:0] MAX_V = DIG_W'(MAX_DIGITS);

   logic [DIG_W-1:0] cnt_inc;

   assign cnt_inc = cnt + DIG_W'(1);

   // clear wins over increment; increments stop once saturated
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         sat <= 1'b0;
      end else if (clr) begin
         cnt <= '0;
         sat <= 1'b0;
      end else if (inc && !sat) begin
         cnt <= cnt_inc;
         sat <= (cnt_inc == MAX_V);
      end
   end

endmodule

// File: rtl/entry_sequencer.sv
// Calculator front-end sequencer: operand digit entry, operator
// select and result display, with registered strobes and flags.
module entry_sequencer
   import entry_seq_pkg::*;
#(
   parameter int N_OPERANDS = 2,
   parameter int MAX_DIGITS = 4,
   parameter int STAGE_W    = $clog2(N_OPERANDS + 2),
   parameter int DIG_W      = $clog2(MAX_DIGITS + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  exe,
   input  logic                  button,
   input  logic                  clear,
   output logic [N_OPERANDS-1:0] trigger_load,
   output logic                  trigger_op,
   output logic                  op_strobe,
   output logic                  result_valid,
   output logic [STAGE_W-1:0]    stage,
   output logic [DIG_W-1:0]      digit_count,
   output logic                  full
);

   localparam logic [STAGE_W-1:0] IDX_LAST = STAGE_W'(N_OPERANDS - 1);
   localparam logic [STAGE_W-1:0] STG_OP   =
      STAGE_W'(N_OPERANDS + STAGE_OP_OFS);
   localparam logic [STAGE_W-1:0] STG_SHOW =
      STAGE_W'(N_OPERANDS + STAGE_SHOW_OFS);

   seq_state_t                state;
   seq_state_t                state_nxt;
   logic [STAGE_W-1:0]        idx;
   logic [STAGE_W-1:0]        idx_nxt;
   logic [STAGE_W-1:0]        stage_nxt;
   logic [N_OPERANDS-1:0]     load_nxt;
   logic                      op_nxt;
   logic                      cnt_inc;
   logic                      cnt_clr;
   logic                      cnt_sat;
   logic [DIG_W-1:0]          cnt;

   // cnt is forced to zero outside ENTRY, so it doubles as digit_count
   entry_digit_counter #(
      .MAX_DIGITS (MAX_DIGITS),
      .DIG_W      (DIG_W)
   ) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (cnt_inc),
      .clr (cnt_clr),
      .cnt (cnt),
      .sat (cnt_sat)
   );

   assign digit_count = cnt;
   assign full        = cnt_sat;

   // next-state decode with priority clear > exe > button
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      op_nxt    = 1'b0;
      cnt_inc   = 1'b0;
      cnt_clr   = 1'b0;
      load_nxt  = '0;
      if (clear) begin
         state_nxt = ENTRY;
         idx_nxt   = '0;
         cnt_clr   = 1'b1;
      end else begin
         unique case (state)
            ENTRY: begin
               if (idx > IDX_LAST) begin
                  idx_nxt = '0;
                  cnt_clr = 1'b1;
               end else if (exe) begin
                  cnt_clr = 1'b1;
                  if (idx < IDX_LAST) begin
                     idx_nxt = idx + STAGE_W'(1);
                  end else begin
                     state_nxt = OP_SELECT;
                     idx_nxt   = '0;
                  end
               end else if (button && !cnt_sat) begin
                  cnt_inc = 1'b1;
               end
            end
            OP_SELECT: begin
               cnt_clr = 1'b1;
               if (!exe && button) begin
                  op_nxt    = 1'b1;
                  state_nxt = OP_ARMED;
               end
            end
            OP_ARMED: begin
               cnt_clr = 1'b1;
               if (exe) begin
                  state_nxt = SHOW;
               end else if (button) begin
                  op_nxt = 1'b1;
               end
            end
            SHOW: begin
               cnt_clr = 1'b1;
               if (exe) begin
                  state_nxt = ENTRY;
                  idx_nxt   = '0;
               end
            end
            default: begin
               state_nxt = ENTRY;
               idx_nxt   = '0;
               cnt_clr   = 1'b1;
            end
         endcase
      end
      for (int i = 0; i < N_OPERANDS; i++) begin
         load_nxt[i] = cnt_inc && (idx == STAGE_W'(i));
      end
      unique case (state_nxt)
         OP_SELECT, OP_ARMED: stage_nxt = STG_OP;
         SHOW:                stage_nxt = STG_SHOW;
         default:             stage_nxt = idx_nxt;
      endcase
   end

   // state, operand index and all registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ENTRY;
         idx          <= '0;
         trigger_load <= '0;
         trigger_op   <= 1'b0;
         op_strobe    <= 1'b0;
         result_valid <= 1'b0;
         stage        <= '0;
      end else begin
         state        <= state_nxt;
         idx          <= idx_nxt;
         trigger_load <= load_nxt;
         trigger_op   <= (state_nxt != ENTRY);
         op_strobe    <= op_nxt;
         result_valid <= (state_nxt == SHOW);
         stage        <= stage_nxt;
      end
   end

endmodule

// File: tb/tb_entry_sequencer.sv
// Directed bench for entry_sequencer with N_OPERANDS=2, MAX_DIGITS=4.
// Observed vector: {load[1:0], op, ops, rv, stage[1:0], dcnt[2:0], full}.
module tb_entry_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       exe = 1'b0;
   logic       button = 1'b0;
   logic       clear = 1'b0;
   logic [1:0] trigger_load;
   logic       trigger_op;
   logic       op_strobe;
   logic       result_valid;
   logic [1:0] stage;
   logic [2:0] digit_count;
   logic       full;
   logic [10:0] obs;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   entry_sequencer #(
      .N_OPERANDS (2),
      .MAX_DIGITS (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .exe          (exe),
      .button       (button),
      .clear        (clear),
      .trigger_load (trigger_load),
      .trigger_op   (trigger_op),
      .op_strobe    (op_strobe),
      .result_valid (result_valid),
      .stage        (stage),
      .digit_count  (digit_count),
      .full         (full)
   );

   assign obs = {trigger_load, trigger_op, op_strobe, result_valid,
                 stage, digit_count, full};

   function automatic logic [10:0] ex(input logic [1:0] ld,
                                      input logic top,
                                      input logic ops,
                                      input logic rv,
                                      input logic [1:0] stg,
                                      input logic [2:0] dc,
                                      input logic fl);
      return {ld, top, ops, rv, stg, dc, fl};
   endfunction

   task automatic step(input logic e, input logic b, input logic c);
      exe    = e;
      button = b;
      clear  = c;
      @(posedge clk);
      #1;
      exe    = 1'b0;
      button = 1'b0;
      clear  = 1'b0;
   endtask

   task automatic test_reset();
      logic [10:0] e;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      e = ex(2'b00, 0, 0, 0, 2'd0, 3'd0, 0);
      tests++;
      if (obs !== e) begin
         fails++;
         $display("FAIL reset: got %h want %h", obs, e);
      end
      step(0, 0, 0);
      tests++;
      if (obs !== e) begin
         fails++;
         $display("FAIL reset_idle: got %h want %h", obs, e);
      end
   endtask

   task automatic test_entry();
      logic [10:0] e;
      for (int i = 1; i <= 3; i++) begin
         step(0, 1, 0);
         e = ex(2'b01, 0, 0, 0, 2'd0, 3'(i), 0);
         tests++;
         if (obs !== e) begin
            fails++;
            $display("FAIL op0_press%0d: got %h want %h", i, obs, e);
         end
      end
      step(1, 0, 0);
      e = ex(2'b00, 0, 0, 0, 2'd1, 3'd0, 0);
      tests++;
      if (obs !== e) begin
         fails++;
         $display("FAIL exe_op1: got %h want %h", obs, e);
      end
      for (int i = 1; i <= 5; i++) begin
         step(0, 1, 0);
         if (i <= 4)
            e = ex(2'b10, 0, 0, 0, 2'd1, 3'(i), i == 4);
         else
            e = ex(2'b00, 0, 0, 0, 2'd1, 3'd4, 1);
         tests++;
         if (obs !== e) begin
            fails++;
            $display("FAIL op1_press%0d: got %h want %h", i, obs, e);
         end
      end
      step(1, 0, 0);
      e = ex(2'b00, 1, 0, 0, 2'd2, 3'd0, 0);
      tests++;
      if (obs !== e) begin
         fails++;
         $display("FAIL exe_opsel: got %h want %h", obs, e);
      end
   endtask

   task automatic test_operator();
      logic [10:0] e;
      step(1, 0, 0);
      e = ex(2'b00, 1, 0, 0, 2'd2, 3'd0, 0);
      tests++;
      if (obs !== e) begin
         fails++;
         $display("FAIL opsel_exe_ignored: got %h want %h", obs, e);
      end
      for (int i = 1; i <= 2; i++) begin
         step(0, 1, 0);
         e = ex(2'b00, 1, 1, 0, 2'd2, 3'd0, 0);
         tests++;
         if (obs !== e) begin
            fails++;
            $display("FAIL op_strobe%0d: got %h want %h", i, obs, e);
         end
      end
      step(0, 0, 0);
      e = ex(2'b00, 1, 0, 0, 2'd2, 3'd0, 0);
      tests++;
      if (obs !== e) begin
         fails++;
         $display("FAIL op_strobe_drop: got %h want %h", obs, e);
      end
      step(1, 0, 0);
      e = ex(2'b00, 1, 0, 1, 2'd3, 3'd0, 0);
      tests++;
      if (obs !== e) begin
         fails++;
         $display("FAIL show: got %h want %h", obs, e);
      end
      step(0, 1, 0);
      tests++;
      if (obs !== e) begin
         fails++;
         $display("FAIL show_button_ignored: got %h want %h", obs, e);
      end
      step(1, 0, 0);
      e = ex(2'b00, 0, 0, 0, 2'd0, 3'd0, 0);
      tests++;
      if (obs !== e) begin
         fails++;
         $display("FAIL show_exit: got %h want %h", obs, e);
      end
   endtask

   task automatic test_same_cycle();
      logic [10:0] e;
      step(0, 1, 0);
      e = ex(2'b01, 0, 0, 0, 2'd0, 3'd1, 0);
      tests++;
      if (obs !== e) begin
         fails++;
         $display("FAIL same_pre: got %h want %h", obs, e);
      end
      step(1, 1, 0);
      e = ex(2'b00, 0, 0, 0, 2'd1, 3'd0, 0);
      tests++;
      if (obs !== e) begin
         fails++;
         $display("FAIL exe_button_same: got %h want %h", obs, e);
      end
   endtask

   task automatic test_clear();
      logic [10:0] e;
      e = ex(2'b00, 0, 0, 0, 2'd0, 3'd0, 0);
      step(1, 0, 0);
      step(0, 1, 0);
      step(0, 0, 0);
      tests++;
      if (obs !== ex(2'b00, 1, 0, 0, 2'd2, 3'd0, 0)) begin
         fails++;
         $display("FAIL clr_armed_pre: got %h want armed", obs);
      end
      step(0, 0, 1);
      tests++;
      if (obs !== e) begin
         fails++;
         $display("FAIL clear_armed: got %h want %h", obs, e);
      end
      step(1, 0, 0);
      step(0, 1, 0);
      step(0, 1, 0);
      tests++;
      if (obs !== ex(2'b10, 0, 0, 0, 2'd1, 3'd2, 0)) begin
         fails++;
         $display("FAIL clr_mid_pre: got %h want idx1 cnt2", obs);
      end
      step(0, 1, 1);
      tests++;
      if (obs !== e) begin
         fails++;
         $display("FAIL clear_mid: got %h want %h", obs, e);
      end
   endtask

   task automatic test_back_to_back();
      logic [10:0] e;
      for (int i = 1; i <= 5; i++) begin
         step(0, 1, 0);
         if (i <= 4)
            e = ex(2'b01, 0, 0, 0, 2'd0, 3'(i), i == 4);
         else
            e = ex(2'b00, 0, 0, 0, 2'd0, 3'd4, 1);
         tests++;
         if (obs !== e) begin
            fails++;
            $display("FAIL b2b_press%0d: got %h want %h", i, obs, e);
         end
      end
      step(0, 0, 0);
      e = ex(2'b00, 0, 0, 0, 2'd0, 3'd4, 1);
      tests++;
      if (obs !== e) begin
         fails++;
         $display("FAIL b2b_idle: got %h want %h", obs, e);
      end
   endtask

   initial begin
      test_reset();
      test_entry();
      test_operator();
      test_same_cycle();
      test_clear();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
